elastic_stage_buffer: RTL and testbench

//  Parametrised elastic pipeline register between two processor stages (e.g. MEM->WB).

---
 rtl/stage_pkg.sv | 20 ++
 rtl/elastic_stage_buffer_if.sv | 29 ++
 rtl/stage_slot.sv | 34 +++
 rtl/elastic_stage_buffer.sv | 143 ++++++++++++++
 tb/tb_elastic_stage_buffer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_pkg.sv
// Shared types and constants for the elastic stage buffer.
package stage_pkg;

  // Default data word width and its word type.
  localparam int WORD_WIDTH = 16;
  typedef logic [WORD_WIDTH-1:0] word_t;

  // Bit positions of the control flags carried with each entry.
  localparam int CTRL_PCSRC    = 0;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 2;

  // Occupancy encodings, also used directly as the control FSM state.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/elastic_stage_buffer_if.sv
// Valid/ready handshake bundle between an upstream and a downstream stage.
interface elastic_stage_buffer_if #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 3,
  parameter int NCTRL  = 3
);

  logic                           in_valid;
  logic                           in_ready;
  logic [NWORDS-1:0][WIDTH-1:0]   in_data;
  logic [NCTRL-1:0]               in_ctrl;
  logic                           out_valid;
  logic                           out_ready;
  logic [NWORDS-1:0][WIDTH-1:0]   out_data;
  logic [NCTRL-1:0]               out_ctrl;

  // The side that feeds entries in and accepts them out (stage logic / bench).
  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  // The buffer itself.
  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );

endinterface

// File: rtl/stage_slot.sv
// One buffer entry: valid flag, data words and control bits.
// Clearing drops only the valid flag so the data stays visible as the last value.
module stage_slot #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 3,
  parameter int NCTRL  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic                         clear,
  input  logic [NWORDS-1:0][WIDTH-1:0] d_data,
  input  logic [NCTRL-1:0]             d_ctrl,
  output logic                         valid,
  output logic [NWORDS-1:0][WIDTH-1:0] q_data,
  output logic [NCTRL-1:0]             q_ctrl
);

  // Entry register: clear wins over load so a flush can never be overridden.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid  <= 1'b0;
      q_data <= '0;
      q_ctrl <= '0;
    end else if (clear) begin
      valid  <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      q_data <= d_data;
      q_ctrl <= d_ctrl;
    end
  end

endmodule

// File: rtl/elastic_stage_buffer.sv
// Elastic pipeline register with a two-entry skid buffer.
// The main slot is always the head; the skid slot catches the one extra entry
// that can arrive while in_ready is still registered high, so in_ready never
// depends combinationally on out_ready.
module elastic_stage_buffer
  import stage_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 3,
  parameter int NCTRL  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  elastic_stage_buffer_if.slave  bus,
  output logic [1:0]             occupancy
);

  occ_e state;
  occ_e next_state;
  logic in_ready_q;

  logic accept;
  logic drain;

  logic main_load;
  logic main_from_skid;
  logic main_clear;
  logic skid_load;
  logic skid_clear;

  logic                         main_valid;
  logic [NWORDS-1:0][WIDTH-1:0] main_data;
  logic [NCTRL-1:0]             main_ctrl;
  logic                         skid_valid;
  logic [NWORDS-1:0][WIDTH-1:0] skid_data;
  logic [NCTRL-1:0]             skid_ctrl;

  logic [NWORDS-1:0][WIDTH-1:0] main_d_data;
  logic [NCTRL-1:0]             main_d_ctrl;

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = main_valid & bus.out_ready;

  // State register; in_ready is registered from the occupancy we are moving to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= OCC_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= next_state;
      in_ready_q <= (next_state != OCC_FULL);
    end
  end

  // Next occupancy from the handshakes; flush empties regardless of traffic.
  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY: if (accept) next_state = OCC_ONE;
        OCC_ONE: begin
          if (accept && !drain)      next_state = OCC_FULL;
          else if (!accept && drain) next_state = OCC_EMPTY;
        end
        OCC_FULL:  if (drain) next_state = OCC_ONE;
        default:   next_state = OCC_EMPTY;
      endcase
    end
  end

  // Slot load/clear decode; skid only ever refills main, never the output directly.
  always_comb begin
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (accept) main_load = 1'b1;
        end
        OCC_ONE: begin
          if (accept && drain) main_load  = 1'b1;
          else if (accept)     skid_load  = 1'b1;
          else if (drain)      main_clear = 1'b1;
        end
        OCC_FULL: begin
          if (drain && skid_valid) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_d_data = main_from_skid ? skid_data : bus.in_data;
  assign main_d_ctrl = main_from_skid ? skid_ctrl : bus.in_ctrl;

  stage_slot #(.WIDTH(WIDTH), .NWORDS(NWORDS), .NCTRL(NCTRL)) u_main (
    .clk    (clk),
    .reset  (reset),
    .load   (main_load),
    .clear  (main_clear),
    .d_data (main_d_data),
    .d_ctrl (main_d_ctrl),
    .valid  (main_valid),
    .q_data (main_data),
    .q_ctrl (main_ctrl)
  );

  stage_slot #(.WIDTH(WIDTH), .NWORDS(NWORDS), .NCTRL(NCTRL)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .load   (skid_load),
    .clear  (skid_clear),
    .d_data (bus.in_data),
    .d_ctrl (bus.in_ctrl),
    .valid  (skid_valid),
    .q_data (skid_data),
    .q_ctrl (skid_ctrl)
  );

  // Control bits are masked by valid so a bubble can never write back or branch.
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data;
  assign bus.out_ctrl  = main_ctrl & {NCTRL{main_valid}};
  assign occupancy     = state;

endmodule

// File: tb/tb_elastic_stage_buffer.sv
// Bench for elastic_stage_buffer: directed steps on the default configuration,
// then a random handshake run on a wide configuration, both against queues.
module tb_elastic_stage_buffer;
  import stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       flush16;
  logic       flush32;
  logic [1:0] occ16;
  logic [1:0] occ32;

  elastic_stage_buffer_if #(.WIDTH(16), .NWORDS(3), .NCTRL(3)) b16 ();
  elastic_stage_buffer_if #(.WIDTH(32), .NWORDS(4), .NCTRL(5)) b32 ();

  elastic_stage_buffer #(.WIDTH(16), .NWORDS(3), .NCTRL(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush16),
    .bus       (b16),
    .occupancy (occ16)
  );

  elastic_stage_buffer #(.WIDTH(32), .NWORDS(4), .NCTRL(5)) dut32 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush32),
    .bus       (b32),
    .occupancy (occ32)
  );

  typedef struct packed {
    logic [2:0][15:0] data;
    logic [2:0]       ctrl;
  } ent16_t;

  typedef struct packed {
    logic [3:0][31:0] data;
    logic [4:0]       ctrl;
  } ent32_t;

  ent16_t q16[$];
  ent32_t q32[$];
  ent16_t last16;
  int     checks = 0;
  int     errors = 0;
  bit     acc16;
  bit     acc32;
  bit     got_c;
  bit     pending;

  // One comparison point: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks both DUTs against their queues, applies this cycle's handshakes
  // to the queues, then advances to the next falling edge.
  task automatic applyStimulus();
    ent16_t n16;
    ent32_t n32;
    bit     rel16;
    bit     rel32;
    checkOutput("occupancy16", 128'(occ16), 128'(q16.size()));
    checkOutput("in_ready16", 128'(b16.in_ready), 128'(q16.size() < 2));
    checkOutput("out_valid16", 128'(b16.out_valid), 128'(q16.size() != 0));
    if (q16.size() != 0) begin
      checkOutput("out_data16", 128'(b16.out_data), 128'(q16[0].data));
      checkOutput("out_ctrl16", 128'(b16.out_ctrl), 128'(q16[0].ctrl));
    end else begin
      checkOutput("bubble_ctrl16", 128'(b16.out_ctrl), 128'(0));
    end
    checkOutput("occupancy32", 128'(occ32), 128'(q32.size()));
    checkOutput("in_ready32", 128'(b32.in_ready), 128'(q32.size() < 2));
    checkOutput("out_valid32", 128'(b32.out_valid), 128'(q32.size() != 0));
    if (q32.size() != 0) begin
      checkOutput("out_data32", 128'(b32.out_data), 128'(q32[0].data));
      checkOutput("out_ctrl32", 128'(b32.out_ctrl), 128'(q32[0].ctrl));
    end else begin
      checkOutput("bubble_ctrl32", 128'(b32.out_ctrl), 128'(0));
    end

    acc16 = b16.in_valid && (q16.size() < 2);
    rel16 = b16.out_ready && (q16.size() != 0);
    n16.data = b16.in_data;
    n16.ctrl = b16.in_ctrl;
    if (flush16) begin
      q16.delete();
    end else begin
      if (rel16) last16 = q16.pop_front();
      if (acc16) q16.push_back(n16);
    end

    acc32 = b32.in_valid && (q32.size() < 2);
    rel32 = b32.out_ready && (q32.size() != 0);
    n32.data = b32.in_data;
    n32.ctrl = b32.in_ctrl;
    if (flush32) begin
      q32.delete();
    end else begin
      if (rel32) void'(q32.pop_front());
      if (acc32) q32.push_back(n32);
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive16(input logic [15:0] base, input logic [2:0] ctrl);
    b16.in_valid   = 1'b1;
    b16.in_data[0] = base;
    b16.in_data[1] = base + 16'd1;
    b16.in_data[2] = base + 16'd2;
    b16.in_ctrl    = ctrl;
  endtask

  initial begin
    reset         = 1'b0;
    flush16       = 1'b0;
    flush32       = 1'b0;
    b16.in_valid  = 1'b0;
    b16.in_data   = '0;
    b16.in_ctrl   = '0;
    b16.out_ready = 1'b0;
    b32.in_valid  = 1'b0;
    b32.in_data   = '0;
    b32.in_ctrl   = '0;
    b32.out_ready = 1'b0;

    // Reset held with traffic offered: nothing may get in.
    $display("[TB] reset");
    drive16(16'h00AA, 3'b111);
    b32.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_occupancy", 128'(occ16), 128'(0));
      checkOutput("rst_out_valid", 128'(b16.out_valid), 128'(0));
      checkOutput("rst_out_ctrl", 128'(b16.out_ctrl), 128'(0));
      checkOutput("rst_out_data", 128'(b16.out_data), 128'(0));
      checkOutput("rst_occupancy32", 128'(occ32), 128'(0));
    end
    b16.in_valid = 1'b0;
    b32.in_valid = 1'b0;
    reset = 1'b1;
    checkOutput("rst_in_ready", 128'(b16.in_ready), 128'(1));

    // Streaming at full rate with a free downstream.
    $display("[TB] streaming");
    b16.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive16(16'(i), 3'(1 << CTRL_REGWRITE));
      applyStimulus();
    end
    b16.in_valid = 1'b0;
    repeat (2) applyStimulus();

    // Backpressure: two entries fill the buffer, the third waits upstream.
    $display("[TB] backpressure");
    b16.out_ready = 1'b0;
    drive16(16'h0A00, 3'b001);
    applyStimulus();
    drive16(16'h0B00, 3'b010);
    applyStimulus();
    checkOutput("bp_occupancy", 128'(occ16), 128'(2));
    checkOutput("bp_in_ready", 128'(b16.in_ready), 128'(0));
    drive16(16'h0C00, 3'b100);
    repeat (2) applyStimulus();
    b16.out_ready = 1'b1;
    got_c = 1'b0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus();
      if (acc16) begin
        got_c = 1'b1;
        break;
      end
    end
    checkOutput("bp_c_accepted", 128'(got_c), 128'(1));
    b16.in_valid = 1'b0;
    repeat (3) applyStimulus();

    // Flush with a full buffer and new input offered.
    $display("[TB] flush");
    b16.out_ready = 1'b0;
    drive16(16'h0D00, 3'b011);
    applyStimulus();
    drive16(16'h0E00, 3'b110);
    applyStimulus();
    drive16(16'h0F00, 3'b111);
    flush16 = 1'b1;
    applyStimulus();
    flush16 = 1'b0;
    b16.in_valid = 1'b0;
    checkOutput("flush_occupancy", 128'(occ16), 128'(0));
    checkOutput("flush_out_valid", 128'(b16.out_valid), 128'(0));
    checkOutput("flush_out_ctrl", 128'(b16.out_ctrl), 128'(0));
    checkOutput("flush_in_ready", 128'(b16.in_ready), 128'(1));
    b16.out_ready = 1'b1;
    repeat (3) applyStimulus();

    // Reset in the middle of holding an entry.
    $display("[TB] reset mid-transfer");
    b16.out_ready = 1'b0;
    drive16(16'h1100, 3'b101);
    applyStimulus();
    b16.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("midrst_occupancy", 128'(occ16), 128'(0));
    checkOutput("midrst_out_valid", 128'(b16.out_valid), 128'(0));
    q16.delete();
    q32.delete();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus();

    // Bubble after an all-ones ctrl entry drains: ctrl masked, data kept.
    $display("[TB] bubble ctrl");
    b16.out_ready = 1'b1;
    drive16(16'h2200, 3'b111);
    applyStimulus();
    b16.in_valid = 1'b0;
    applyStimulus();
    checkOutput("bubble_out_valid", 128'(b16.out_valid), 128'(0));
    checkOutput("bubble_out_ctrl", 128'(b16.out_ctrl), 128'(0));
    checkOutput("bubble_out_data", 128'(b16.out_data), 128'(last16.data));
    checkOutput("bubble_last_ctrl", 128'(last16.ctrl), 128'(3'b111));
    applyStimulus();

    // Wide configuration under random valid/ready with occasional flush.
    $display("[TB] random wide");
    pending = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (!pending) begin
        b32.in_valid = 1'($urandom_range(0, 1));
        for (int w = 0; w < 4; w++) b32.in_data[w] = $urandom();
        b32.in_ctrl = 5'($urandom());
      end
      b32.out_ready = 1'($urandom_range(0, 1));
      flush32 = ($urandom_range(0, 49) == 0);
      applyStimulus();
      pending = b32.in_valid && !acc32 && !flush32;
    end
    b32.in_valid  = 1'b0;
    b32.out_ready = 1'b1;
    flush32       = 1'b0;
    repeat (3) applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
